// File: rtl/sprite_fetch_pkg.sv
// sprite_fetch_pkg: shared types, sprite heights, default address width and bit reversal for the sprite tile fetcher
package sprite_fetch_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_LO = 2'd1,
      RD_HI = 2'd2,
      LOAD  = 2'd3
   } state_t;
   localparam int SPR_H_SHORT = 8;
   localparam int SPR_H_TALL  = 16;
   localparam int DEF_ADDR_W  = 13;
   function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction
endpackage

// File: rtl/sprite_tile_fetcher.sv
// sprite_tile_fetcher: fetches one sprite row (two bitplanes) from VRAM, applies flips, strobes it into the pixel shifter with a merge mask
// Ports: clk/reset (async active-high); start/abort control; tile_idx, line, tall, yflip, xflip describe the row;
// cur_pix_a/b are the shifter contents for the mask; vram_addr/vram_rd/vram_rdata form the read port;
// busy, plane_a, plane_b, load_mask, load feed the shifter.
module sprite_tile_fetcher
   import sprite_fetch_pkg::*;
#(
   parameter int FETCH_WAIT = 1,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        tile_idx,
   input  logic [3:0]        line,
   input  logic              tall,
   input  logic              yflip,
   input  logic              xflip,
   input  logic [7:0]        cur_pix_a,
   input  logic [7:0]        cur_pix_b,
   input  logic [7:0]        vram_rdata,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_rd,
   output logic              busy,
   output logic [7:0]        plane_a,
   output logic [7:0]        plane_b,
   output logic [7:0]        load_mask,
   output logic              load
);
   localparam logic [3:0] H_S_M1 = 4'(SPR_H_SHORT - 1);
   localparam logic [3:0] H_T_M1 = 4'(SPR_H_TALL - 1);
   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [7:0]  r_tile;
   logic [3:0]  r_line;
   logic        r_tall;
   logic        r_yflip;
   logic        r_xflip;
   logic [7:0]  r_lo;
   logic [7:0]  r_plane_a;
   logic [7:0]  r_plane_b;
   logic        w_busy;
   logic        w_last;
   logic [3:0]  w_line_p;
   logic [3:0]  w_row;
   logic [7:0]  w_tile;
   logic [ADDR_W-1:0] w_addr;
   // a tall sprite occupies an even/odd tile pair, so the row index spans both tiles
   assign w_line_p = r_tall ? r_line : {1'b0, r_line[2:0]};
   assign w_row    = r_yflip ? (r_tall ? H_T_M1 : H_S_M1) - w_line_p : w_line_p;
   assign w_tile   = r_tall ? {r_tile[7:1], 1'b0} : r_tile;
   assign w_addr   = ADDR_W'({w_tile, 4'b0000}) + ADDR_W'({w_row, 1'b0}) + ADDR_W'(r_state == RD_HI);
   assign w_busy   = (r_state == RD_LO) || (r_state == RD_HI);
   assign w_last   = (r_cnt == 3'(FETCH_WAIT));
   assign busy      = w_busy;
   assign vram_rd   = w_busy;
   assign vram_addr = w_busy ? w_addr : '0;
   assign load      = (r_state == LOAD);
   // only transparent slots (both planes zero) may be overwritten by the new row
   assign load_mask = load ? ~(cur_pix_a | cur_pix_b) : 8'h00;
   assign plane_a   = r_plane_a;
   assign plane_b   = r_plane_b;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_tile    <= '0;
         r_line    <= '0;
         r_tall    <= 1'b0;
         r_yflip   <= 1'b0;
         r_xflip   <= 1'b0;
         r_lo      <= '0;
         r_plane_a <= '0;
         r_plane_b <= '0;
      end else if (abort) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE, LOAD: begin
               if (start) begin
                  r_tile  <= tile_idx;
                  r_line  <= line;
                  r_tall  <= tall;
                  r_yflip <= yflip;
                  r_xflip <= xflip;
                  r_cnt   <= '0;
                  r_state <= RD_LO;
               end else begin
                  r_state <= IDLE;
               end
            end
            RD_LO: begin
               if (w_last) begin
                  r_lo    <= vram_rdata;
                  r_cnt   <= '0;
                  r_state <= RD_HI;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            RD_HI: begin
               if (w_last) begin
                  // the high byte goes straight into plane_b; it is only needed once
                  r_plane_a <= r_xflip ? bit_reverse8(r_lo) : r_lo;
                  r_plane_b <= r_xflip ? bit_reverse8(vram_rdata) : vram_rdata;
                  r_cnt     <= '0;
                  r_state   <= LOAD;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_tile_fetcher.sv
// tb_sprite_tile_fetcher: directed checks of the sprite tile fetcher with default and long VRAM wait
module tb_sprite_tile_fetcher;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  tile_idx = '0;
   logic [3:0]  line = '0;
   logic        tall = 1'b0;
   logic        yflip = 1'b0;
   logic        xflip = 1'b0;
   logic [7:0]  cur_pix_a = '0;
   logic [7:0]  cur_pix_b = '0;
   logic [7:0]  mem [0:8191];
   logic [12:0] addr0, addr1;
   logic [7:0]  rdata0, rdata1;
   logic        rd0, rd1, busy0, busy1, load0, load1;
   logic [7:0]  pa0, pa1, pb0, pb1, lm0, lm1;
   logic        sel = 1'b0;
   logic [12:0] m_addr;
   logic        m_rd, m_busy, m_load;
   logic [7:0]  m_pa, m_pb, m_lm;
   int          total = 0;
   int          bad = 0;
   always #5 clk = ~clk;
   assign rdata0 = mem[addr0];
   assign rdata1 = mem[addr1];
   assign m_addr = sel ? addr1 : addr0;
   assign m_rd   = sel ? rd1 : rd0;
   assign m_busy = sel ? busy1 : busy0;
   assign m_load = sel ? load1 : load0;
   assign m_pa   = sel ? pa1 : pa0;
   assign m_pb   = sel ? pb1 : pb0;
   assign m_lm   = sel ? lm1 : lm0;
   sprite_tile_fetcher #(.FETCH_WAIT(1), .ADDR_W(13)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .tile_idx(tile_idx), .line(line),
      .tall(tall), .yflip(yflip), .xflip(xflip), .cur_pix_a(cur_pix_a), .cur_pix_b(cur_pix_b),
      .vram_rdata(rdata0), .vram_addr(addr0), .vram_rd(rd0), .busy(busy0), .plane_a(pa0),
      .plane_b(pb0), .load_mask(lm0), .load(load0)
   );
   sprite_tile_fetcher #(.FETCH_WAIT(3), .ADDR_W(13)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .tile_idx(tile_idx), .line(line),
      .tall(tall), .yflip(yflip), .xflip(xflip), .cur_pix_a(cur_pix_a), .cur_pix_b(cur_pix_b),
      .vram_rdata(rdata1), .vram_addr(addr1), .vram_rd(rd1), .busy(busy1), .plane_a(pa1),
      .plane_b(pb1), .load_mask(lm1), .load(load1)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic all_zero(input string tag);
      chk({tag, " addr"}, 32'(m_addr), 0);
      chk({tag, " rd"}, 32'(m_rd), 0);
      chk({tag, " busy"}, 32'(m_busy), 0);
      chk({tag, " load"}, 32'(m_load), 0);
      chk({tag, " pa"}, 32'(m_pa), 0);
      chk({tag, " pb"}, 32'(m_pb), 0);
      chk({tag, " mask"}, 32'(m_lm), 0);
   endtask
   task automatic idle_chk(input string tag);
      step();
      chk({tag, " idle busy"}, 32'(m_busy), 0);
      chk({tag, " idle rd"}, 32'(m_rd), 0);
      chk({tag, " idle load"}, 32'(m_load), 0);
      chk({tag, " idle mask"}, 32'(m_lm), 0);
   endtask
   // Drives a request, then walks every read cycle and the load cycle; returns in the LOAD cycle.
   task automatic fetch(input string tag, input logic [7:0] t, input logic [3:0] ln, input logic tl,
                        input logic yf, input logic xf, input logic [7:0] ca, input logic [7:0] cb,
                        input logic [12:0] a_lo, input logic [7:0] e_a, input logic [7:0] e_b,
                        input logic [7:0] e_m, input logic poke);
      int w;
      w = sel ? 3 : 1;
      tile_idx = t; line = ln; tall = tl; yflip = yf; xflip = xf;
      cur_pix_a = ca; cur_pix_b = cb;
      start = 1'b1;
      for (int c = 0; c < 2 * (w + 1); c++) begin
         step();
         if (c == 0 && poke) tile_idx = 8'hEE;
         else start = 1'b0;
         chk({tag, " rd"}, 32'(m_rd), 1);
         chk({tag, " busy"}, 32'(m_busy), 1);
         chk({tag, " early load"}, 32'(m_load), 0);
         chk({tag, " addr"}, 32'(m_addr), 32'(c < w + 1 ? a_lo : a_lo + 13'd1));
      end
      step();
      chk({tag, " load"}, 32'(m_load), 1);
      chk({tag, " load busy"}, 32'(m_busy), 0);
      chk({tag, " load rd"}, 32'(m_rd), 0);
      chk({tag, " plane_a"}, 32'(m_pa), 32'(e_a));
      chk({tag, " plane_b"}, 32'(m_pb), 32'(e_b));
      chk({tag, " mask"}, 32'(m_lm), 32'(e_m));
   endtask
   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      mem[13'h126] = 8'hA5; mem[13'h127] = 8'h3C;
      mem[13'h134] = 8'h11; mem[13'h135] = 8'h22;
      mem[13'h13E] = 8'h0F; mem[13'h13F] = 8'hF0;
      mem[13'h128] = 8'h35; mem[13'h129] = 8'hC1;
      step();
      step();
      all_zero("reset");
      reset = 1'b0;
      idle_chk("post reset");
      fetch("basic", 8'h12, 4'd3, 0, 0, 0, 8'hF0, 8'h0C, 13'h126, 8'hA5, 8'h3C, 8'h03, 0);
      idle_chk("basic");
      fetch("xflip pal", 8'h12, 4'hB, 0, 0, 1, 8'h00, 8'h00, 13'h126, 8'hA5, 8'h3C, 8'hFF, 0);
      idle_chk("xflip pal");
      mem[13'h126] = 8'h01; mem[13'h127] = 8'h80;
      fetch("xflip", 8'h12, 4'd3, 0, 0, 1, 8'h81, 8'h42, 13'h126, 8'h80, 8'h01, 8'h3C, 0);
      idle_chk("xflip");
      chk("hold plane_a", 32'(m_pa), 32'h80);
      fetch("tall", 8'h13, 4'd10, 1, 0, 0, 8'hFF, 8'h00, 13'h134, 8'h11, 8'h22, 8'h00, 0);
      idle_chk("tall");
      fetch("tall yflip", 8'h13, 4'd0, 1, 1, 0, 8'h00, 8'h01, 13'h13E, 8'h0F, 8'hF0, 8'hFE, 0);
      idle_chk("tall yflip");
      fetch("yflip xflip", 8'h12, 4'd3, 0, 1, 1, 8'h00, 8'h00, 13'h128, 8'hAC, 8'h83, 8'hFF, 0);
      idle_chk("yflip xflip");
      mem[13'h126] = 8'hA5; mem[13'h127] = 8'h3C;
      fetch("start in rd_lo", 8'h12, 4'd3, 0, 0, 0, 8'h00, 8'h00, 13'h126, 8'hA5, 8'h3C, 8'hFF, 1);
      idle_chk("not queued");
      fetch("chain a", 8'h13, 4'd10, 1, 0, 0, 8'h00, 8'h00, 13'h134, 8'h11, 8'h22, 8'hFF, 0);
      fetch("chain b", 8'h13, 4'd0, 1, 1, 0, 8'h00, 8'h00, 13'h13E, 8'h0F, 8'hF0, 8'hFF, 0);
      idle_chk("chain");
      tile_idx = 8'h12; line = 4'd3; tall = 0; yflip = 0; xflip = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("abort rd_hi addr", 32'(m_addr), 32'h127);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort busy", 32'(m_busy), 0);
      chk("abort rd", 32'(m_rd), 0);
      chk("abort load", 32'(m_load), 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("abort no load", 32'(m_load), 0);
         chk("abort busy later", 32'(m_busy), 0);
      end
      chk("abort hold pa", 32'(m_pa), 32'h0F);
      chk("abort hold pb", 32'(m_pb), 32'hF0);
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("start+abort busy", 32'(m_busy), 0);
      chk("start+abort rd", 32'(m_rd), 0);
      idle_chk("start+abort");
      start = 1'b1;
      step();
      start = 1'b0;
      chk("pre reset busy", 32'(m_busy), 1);
      #2;
      reset = 1'b1;
      #1;
      all_zero("async reset");
      step();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("reset no load", 32'(m_load), 0);
      end
      sel = 1'b1;
      #0;
      fetch("wait3", 8'h12, 4'd3, 0, 0, 0, 8'hF0, 8'h0C, 13'h126, 8'hA5, 8'h3C, 8'h03, 0);
      idle_chk("wait3");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
